// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic-light monitor: decoded phase, lamp sample, lamp decode and
// a saturating 16-bit increment used when a phase length must include the current cycle.
package traffic_lights_pkg;

  typedef enum logic [3:0] {
    UNKNOWN     = 4'd0,
    RED         = 4'd1,
    RED_YELLOW  = 4'd2,
    GREEN       = 4'd3,
    GREEN_BLINK = 4'd4,
    YELLOW      = 4'd5,
    YEL_BLINK   = 4'd6,
    OFF         = 4'd7
  } phase_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  // Dark and illegal combinations both map to UNKNOWN; callers tell them apart.
  function automatic phase_t decode_lamp(lamp_t l);
    case ({l.r, l.y, l.g})
      3'b100:  return RED;
      3'b110:  return RED_YELLOW;
      3'b001:  return GREEN;
      3'b010:  return YELLOW;
      default: return UNKNOWN;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tl_sat_counter.sv
// Saturating counter: sync clear > load-1 > increment, sticks at all-ones.
// Count visible the cycle after the control input; no backpressure.
module tl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)
      cnt_o <= '0;
    else if (clr_i)
      cnt_o <= '0;
    else if (load_i)
      cnt_o <= {{(W-1){1'b0}}, 1'b1};
    else if (inc_i && (cnt_o != {W{1'b1}}))
      cnt_o <= cnt_o + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/traffic_lights_monitor.sv
// Lamp observer: decodes phase, measures phase length and green blinks, flags sequence errors.
// All outputs registered one cycle after the lamp sample; pure observer, never stalls.
module traffic_lights_monitor
  import traffic_lights_pkg::*;
#(
  parameter logic [15:0] BLINK_HALF_PERIOD = 16'd500,
  parameter logic [15:0] GREEN_BLINKS_NUM  = 16'd4,
  parameter logic [15:0] DARK_TIMEOUT      = 16'd1000
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        clr_i,
  input  logic        red_i,
  input  logic        yellow_i,
  input  logic        green_i,
  output logic [3:0]  phase_o,
  output logic        event_valid_o,
  output logic [3:0]  event_phase_o,
  output logic [15:0] event_len_o,
  output logic [7:0]  event_blinks_o,
  output logic        seq_err_o,
  output logic        blink_err_o,
  output logic        err_sticky_o
);

  // A dark gap inside a blink phase must never be mistaken for lamps switched off.
  if (DARK_TIMEOUT <= BLINK_HALF_PERIOD) begin : g_bad_params
    $error("DARK_TIMEOUT must exceed BLINK_HALF_PERIOD");
  end

  phase_t      phase_q, nxt;
  lamp_t       lamp, prev_lamp;
  phase_t      dec;
  logic        dark, illegal, dark_hit, stay, legal, seqe, ev, blinke, blink_inc;
  logic [15:0] len_cnt, dark_cnt, ev_len;
  logic [7:0]  blink_cnt;

  assign lamp     = '{r: red_i, y: yellow_i, g: green_i};
  assign dec      = decode_lamp(lamp);
  assign dark     = (lamp == 3'b000);
  assign illegal  = !dark && (dec == UNKNOWN);
  assign dark_hit = dark && (phase_q != OFF) && (sat_inc16(dark_cnt) == DARK_TIMEOUT);

  always_comb begin
    stay  = (dec == phase_q) ||
            (phase_q == GREEN_BLINK && dec == GREEN) ||
            (phase_q == YEL_BLINK   && dec == YELLOW);
    legal = (phase_q == RED         && dec == RED_YELLOW) ||
            (phase_q == RED_YELLOW  && dec == GREEN) ||
            (phase_q == GREEN_BLINK && dec == YELLOW) ||
            (phase_q == YELLOW      && dec == RED) ||
            (phase_q == YEL_BLINK   && dec == RED);
    nxt   = phase_q;
    seqe  = 1'b0;
    if (illegal) begin
      nxt  = UNKNOWN;
      seqe = 1'b1;
    end else if (dark_hit) begin
      nxt = OFF;
    end else if (dark) begin
      if (phase_q == GREEN)       nxt = GREEN_BLINK;
      else if (phase_q == YELLOW) nxt = YEL_BLINK;
    end else if (phase_q == UNKNOWN || phase_q == OFF) begin
      nxt = dec;
    end else if (!stay) begin
      nxt  = dec;
      seqe = !legal;
    end
  end

  // An aborted (illegal) phase is discarded rather than reported.
  assign ev        = !illegal && (nxt != phase_q) && (phase_q != UNKNOWN) && (phase_q != OFF);
  assign ev_len    = dark_hit ? sat_inc16(len_cnt) : len_cnt;
  assign blinke    = ev && (phase_q == GREEN_BLINK) && (blink_cnt != GREEN_BLINKS_NUM[7:0]);
  assign blink_inc = (phase_q == GREEN_BLINK) && (prev_lamp == 3'b000) && (lamp == 3'b001);

  tl_sat_counter #(.W(16)) u_len_cnt (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .clr_i(clr_i),
    .load_i(nxt != phase_q), .inc_i(1'b1), .cnt_o(len_cnt)
  );

  tl_sat_counter #(.W(16)) u_dark_cnt (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .clr_i(clr_i || !dark),
    .load_i(1'b0), .inc_i(dark), .cnt_o(dark_cnt)
  );

  tl_sat_counter #(.W(8)) u_blink_cnt (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .clr_i(clr_i || (nxt == GREEN_BLINK && phase_q != GREEN_BLINK)),
    .load_i(1'b0), .inc_i(blink_inc), .cnt_o(blink_cnt)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      phase_q        <= UNKNOWN;
      prev_lamp      <= '0;
      event_valid_o  <= 1'b0;
      event_phase_o  <= '0;
      event_len_o    <= '0;
      event_blinks_o <= '0;
      seq_err_o      <= 1'b0;
      blink_err_o    <= 1'b0;
      err_sticky_o   <= 1'b0;
    end else if (clr_i) begin
      phase_q        <= UNKNOWN;
      prev_lamp      <= '0;
      event_valid_o  <= 1'b0;
      event_phase_o  <= '0;
      event_len_o    <= '0;
      event_blinks_o <= '0;
      seq_err_o      <= 1'b0;
      blink_err_o    <= 1'b0;
      err_sticky_o   <= 1'b0;
    end else begin
      phase_q       <= nxt;
      prev_lamp     <= lamp;
      event_valid_o <= ev;
      if (ev) begin
        event_phase_o  <= phase_q;
        event_len_o    <= ev_len;
        event_blinks_o <= (phase_q == GREEN_BLINK) ? blink_cnt : 8'd0;
      end
      seq_err_o    <= seqe;
      blink_err_o  <= blinke;
      err_sticky_o <= err_sticky_o || seqe || blinke;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: tb/tb_traffic_lights_monitor.sv
// Directed bench for traffic_lights_monitor: lamp sequences with hand-computed events and errors.
module tb_traffic_lights_monitor;
  import traffic_lights_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        clr_i;
  logic        red_i, yellow_i, green_i;
  logic [3:0]  phase_o;
  logic        event_valid_o;
  logic [3:0]  event_phase_o;
  logic [15:0] event_len_o;
  logic [7:0]  event_blinks_o;
  logic        seq_err_o, blink_err_o, err_sticky_o;

  traffic_lights_monitor dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .clr_i(clr_i),
    .red_i(red_i), .yellow_i(yellow_i), .green_i(green_i),
    .phase_o(phase_o), .event_valid_o(event_valid_o), .event_phase_o(event_phase_o),
    .event_len_o(event_len_o), .event_blinks_o(event_blinks_o),
    .seq_err_o(seq_err_o), .blink_err_o(blink_err_o), .err_sticky_o(err_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // Event log filled from the falling edge; the stimulus process only reads it.
  logic [27:0] ev_buf [0:255];
  int ev_wr = 0, n_seq = 0, n_blink = 0;
  int ev_rd = 0, seq_base = 0, blink_base = 0;

  always @(negedge clk_i) begin
    if (arst_n_i) begin
      if (event_valid_o) begin
        ev_buf[ev_wr[7:0]] <= {event_phase_o, event_len_o, event_blinks_o};
        ev_wr <= ev_wr + 1;
      end
      if (seq_err_o)   n_seq   <= n_seq + 1;
      if (blink_err_o) n_blink <= n_blink + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [2:0] ryg, input int n);
    {red_i, yellow_i, green_i} = ryg;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_clr();
    {red_i, yellow_i, green_i} = 3'b000;
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    ev_rd      = ev_wr;
    seq_base   = n_seq;
    blink_base = n_blink;
  endtask

  task automatic expect_ev(input string tag, input phase_t ph, input logic [15:0] len,
                           input logic [7:0] blinks);
    logic [27:0] e;
    check({tag, "_present"}, 32'(ev_wr > ev_rd), 32'd1);
    if (ev_wr > ev_rd) begin
      e = ev_buf[ev_rd[7:0]];
      ev_rd++;
      check({tag, "_phase"},  32'(e[27:24]), 32'(ph));
      check({tag, "_len"},    32'(e[23:8]),  32'(len));
      check({tag, "_blinks"}, 32'(e[7:0]),   32'(blinks));
    end
  endtask

  task automatic expect_tail(input string tag, input int seqs, input int blinks);
    check({tag, "_no_extra_ev"}, 32'(ev_wr - ev_rd), 32'd0);
    check({tag, "_seq_err_cnt"}, 32'(n_seq - seq_base), 32'(seqs));
    check({tag, "_blink_err_cnt"}, 32'(n_blink - blink_base), 32'(blinks));
  endtask

  initial begin
    arst_n_i = 1'b0;
    clr_i    = 1'b0;
    {red_i, yellow_i, green_i} = 3'b000;
    repeat (2) @(negedge clk_i);
    check("rst_phase", 32'(phase_o), 32'(UNKNOWN));
    check("rst_ev_vld", 32'(event_valid_o), 32'd0);
    check("rst_ev_len", 32'(event_len_o), 32'd0);
    check("rst_ev_phase", 32'(event_phase_o), 32'd0);
    check("rst_errs", 32'({seq_err_o, blink_err_o, err_sticky_o}), 32'd0);
    arst_n_i = 1'b1;

    // 1: full legal cycle, four blinks
    do_clr();
    hold(3'b100, 100);
    hold(3'b110, 30);
    hold(3'b001, 80);
    for (int i = 0; i < 4; i++) begin
      hold(3'b000, 5);
      hold(3'b001, 5);
    end
    hold(3'b010, 30);
    hold(3'b100, 3);
    expect_ev("c1_red",    RED,         16'd100, 8'd0);
    expect_ev("c1_ry",     RED_YELLOW,  16'd30,  8'd0);
    expect_ev("c1_green",  GREEN,       16'd80,  8'd0);
    expect_ev("c1_gblink", GREEN_BLINK, 16'd40,  8'd4);
    expect_ev("c1_yellow", YELLOW,      16'd30,  8'd0);
    expect_tail("c1", 0, 0);
    check("c1_phase", 32'(phase_o), 32'(RED));
    check("c1_sticky", 32'(err_sticky_o), 32'd0);

    // 2: only three blinks
    do_clr();
    hold(3'b001, 20);
    for (int i = 0; i < 3; i++) begin
      hold(3'b000, 5);
      hold(3'b001, 5);
    end
    hold(3'b010, 10);
    expect_ev("c2_green",  GREEN,       16'd20, 8'd0);
    expect_ev("c2_gblink", GREEN_BLINK, 16'd30, 8'd3);
    expect_tail("c2", 0, 1);
    check("c2_sticky", 32'(err_sticky_o), 32'd1);

    // 3: RED straight to GREEN
    do_clr();
    hold(3'b100, 20);
    hold(3'b001, 5);
    expect_ev("c3_red", RED, 16'd20, 8'd0);
    expect_tail("c3", 1, 0);
    check("c3_phase", 32'(phase_o), 32'(GREEN));
    check("c3_sticky", 32'(err_sticky_o), 32'd1);
    do_clr();
    check("clr_sticky", 32'(err_sticky_o), 32'd0);
    check("clr_phase", 32'(phase_o), 32'(UNKNOWN));

    // 4: illegal 101 glitch during GREEN aborts the phase
    hold(3'b001, 20);
    hold(3'b101, 1);
    check("c4_phase_abort", 32'(phase_o), 32'(UNKNOWN));
    hold(3'b001, 5);
    expect_tail("c4", 1, 0);
    check("c4_phase_after", 32'(phase_o), 32'(GREEN));

    // 5: YELLOW then lamps dark until timeout
    do_clr();
    hold(3'b010, 30);
    hold(3'b000, 999);
    check("c5_phase_yb", 32'(phase_o), 32'(YEL_BLINK));
    hold(3'b000, 1);
    check("c5_phase_off", 32'(phase_o), 32'(OFF));
    hold(3'b000, 5);
    expect_ev("c5_yellow", YELLOW,    16'd30,   8'd0);
    expect_ev("c5_yblink", YEL_BLINK, 16'd1000, 8'd0);
    expect_tail("c5", 0, 0);
    check("c5_phase_stays_off", 32'(phase_o), 32'(OFF));

    // 6: async reset mid-GREEN with the sticky flag set
    do_clr();
    hold(3'b100, 5);
    hold(3'b001, 40);
    arst_n_i = 1'b0;
    #1;
    check("c6_rst_phase", 32'(phase_o), 32'(UNKNOWN));
    check("c6_rst_outs", 32'({event_valid_o, seq_err_o, blink_err_o, err_sticky_o}), 32'd0);
    check("c6_rst_len", 32'(event_len_o), 32'd0);
    hold(3'b001, 3);
    arst_n_i = 1'b1;
    ev_rd      = ev_wr;
    seq_base   = n_seq;
    blink_base = n_blink;
    hold(3'b001, 25);
    hold(3'b000, 3);
    expect_ev("c6_green", GREEN, 16'd25, 8'd0);
    expect_tail("c6", 0, 0);

    // 7: RED long enough to saturate the length counter
    do_clr();
    hold(3'b100, 66000);
    hold(3'b110, 3);
    expect_ev("c7_red_sat", RED, 16'hFFFF, 8'd0);
    expect_tail("c7", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
